// File: rtl/lc3b_types.sv
// Shared LC-3b types: word type, control word and the memory-stage state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Control bits carried down the pipeline alongside each instruction.
  typedef struct packed {
    logic load_regfile;
    logic load_cc;
    logic mem_read;
    logic mem_write;
    logic mem_byte;
    logic mem_indirect;
  } lc3b_control_word;

  // Memory stage sequencing: first access, then (indirect only) the final access.
  typedef enum logic {
    S_FIRST = 1'b0,
    S_FINAL = 1'b1
  } lc3b_mem_state;

  // Data memory is word-addressed on the bus; byte selection happens via lane enables.
  function automatic lc3b_word word_align(input lc3b_word a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the memory stage: lane enables, store-data
// replication and load-byte extraction with sign extension.
module mem_align
  import lc3b_types::*;
(
  input  logic        addr_lsb,
  input  logic        byte_op,
  input  logic [15:0] store_data,
  input  logic [15:0] load_raw,
  output logic [1:0]  byte_enable,
  output logic [15:0] wdata,
  output logic [15:0] load_data
);

  function automatic lc3b_word sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

  // Select lanes and shape store/load data for word or byte accesses.
  always_comb begin
    byte_enable = 2'b11;
    wdata       = store_data;
    load_data   = load_raw;
    if (byte_op) begin
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
      wdata       = {store_data[7:0], store_data[7:0]};
      load_data   = sext8(addr_lsb ? load_raw[15:8] : load_raw[7:0]);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b memory-access stage: issues word, byte and two-access indirect
// data-memory transactions, aligns load data and stalls the front of the
// pipeline until the current transaction completes.
module mem_stage
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [15:0]      pc_in,
  input  logic [15:0]      instruction_in,
  input  logic [15:0]      sr2_in,
  input  logic [15:0]      aluval_in,
  input  lc3b_control_word control_in,
  input  logic [15:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic [15:0]      dmem_address,
  output logic [15:0]      dmem_wdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_byte_enable,
  output logic [15:0]      pc_out,
  output logic [15:0]      instruction_out,
  output logic [15:0]      aluval_out,
  output lc3b_control_word control_out,
  output logic [15:0]      mdr_out,
  output logic             mem_done,
  output logic             stall_out
);

  lc3b_mem_state state, next_state;
  logic [15:0]   ind_addr;

  logic          mem_op;
  logic          first_ind;
  logic          byte_op;
  logic [15:0]   req_addr;
  logic [1:0]    align_be;
  logic [15:0]   align_wdata;
  logic [15:0]   align_load;

  assign mem_op    = valid_in & (control_in.mem_read | control_in.mem_write);
  // The pointer fetch of LDI/STI is always a word read.
  assign first_ind = (state == S_FIRST) & control_in.mem_indirect;
  // Indirect ops are word accesses; mem_byte only applies to direct ones.
  assign byte_op   = control_in.mem_byte & ~control_in.mem_indirect;
  assign req_addr  = (state == S_FINAL) ? ind_addr : aluval_in;

  // Non-memory fields go straight through to the MEM/WB latch.
  assign pc_out          = pc_in;
  assign instruction_out = instruction_in;
  assign aluval_out      = aluval_in;
  assign control_out     = control_in;

  mem_align u_align (
    .addr_lsb    (req_addr[0]),
    .byte_op     (byte_op),
    .store_data  (sr2_in),
    .load_raw    (dmem_rdata),
    .byte_enable (align_be),
    .wdata       (align_wdata),
    .load_data   (align_load)
  );

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FIRST;
    else       state <= next_state;
  end

  // Capture the pointer returned by the first access of an indirect op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ind_addr <= 16'h0000;
    else if (first_ind && mem_op && dmem_resp)
      ind_addr <= dmem_rdata;
  end

  // Advance only on a response to a request that is actually outstanding.
  always_comb begin
    next_state = state;
    case (state)
      S_FIRST: if (mem_op && control_in.mem_indirect && dmem_resp) next_state = S_FINAL;
      S_FINAL: if (mem_op && dmem_resp) next_state = S_FIRST;
      default: next_state = S_FIRST;
    endcase
  end

  // Drive the request, completion and stall for the current access.
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    mem_done         = 1'b0;
    stall_out        = 1'b0;
    dmem_address     = word_align(req_addr);
    dmem_wdata       = align_wdata;
    dmem_byte_enable = align_be;
    mdr_out          = align_load;
    if (!reset && mem_op) begin
      if (first_ind) begin
        dmem_read = 1'b1;
      end else begin
        dmem_read  = control_in.mem_read;
        dmem_write = control_in.mem_write;
      end
      mem_done  = dmem_resp & ~first_ind;
      stall_out = ~mem_done;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected requests and
// completions; a negedge monitor pops and compares them as the DUT shows them.
module tb_mem_stage;
  import lc3b_types::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [15:0]      pc_in, instruction_in, sr2_in, aluval_in, dmem_rdata;
  lc3b_control_word control_in;
  logic             dmem_resp;
  logic [15:0]      dmem_address, dmem_wdata;
  logic             dmem_read, dmem_write;
  logic [1:0]       dmem_byte_enable;
  logic [15:0]      pc_out, instruction_out, aluval_out, mdr_out;
  lc3b_control_word control_out;
  logic             mem_done, stall_out;

  mem_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
    .instruction_in(instruction_in), .sr2_in(sr2_in), .aluval_in(aluval_in),
    .control_in(control_in), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable), .pc_out(pc_out),
    .instruction_out(instruction_out), .aluval_out(aluval_out),
    .control_out(control_out), .mdr_out(mdr_out), .mem_done(mem_done),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } req_t;

  typedef struct {
    logic        chk_mdr;
    logic [15:0] mdr;
    int          stalls;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic lc3b_control_word mk(input logic rd, input logic wr,
                                          input logic byt, input logic ind);
    lc3b_control_word c;
    c = '0;
    c.load_regfile = rd;
    c.mem_read     = rd;
    c.mem_write    = wr;
    c.mem_byte     = byt;
    c.mem_indirect = ind;
    return c;
  endfunction

  task automatic exp_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [1:0] be, input logic [15:0] wd);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.be = be; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic exp_done(input logic chk, input logic [15:0] mdr, input int stalls);
    done_t d;
    d.chk_mdr = chk; d.mdr = mdr; d.stalls = stalls;
    done_q.push_back(d);
  endtask

  // Monitor state
  logic        pending = 1'b0;
  req_t        held;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    req_t  r;
    done_t d;
    if (reset) begin
      pending   = 1'b0;
      stall_cnt = 0;
    end else begin
      if (dmem_read || dmem_write) begin
        if (pending) begin
          check("req_hold", {dmem_read, dmem_write, dmem_address, dmem_byte_enable,
                             (dmem_write ? dmem_wdata : 16'h0)},
                            {held.rd, held.wr, held.addr, held.be,
                             (held.wr ? held.wdata : 16'h0)});
        end else if (req_q.size() == 0) begin
          check("unexpected_req", {dmem_read, dmem_write, dmem_address}, 64'h0);
        end else begin
          r = req_q.pop_front();
          check("req_rw",   {dmem_read, dmem_write}, {r.rd, r.wr});
          check("req_addr", dmem_address, r.addr);
          check("req_be",   dmem_byte_enable, r.be);
          if (r.wr) check("req_wdata", dmem_wdata, r.wdata);
        end
        held.rd = dmem_read; held.wr = dmem_write; held.addr = dmem_address;
        held.be = dmem_byte_enable; held.wdata = dmem_wdata;
      end
      if (stall_out) stall_cnt++;
      if (mem_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", mem_done, 1'b0);
        end else begin
          d = done_q.pop_front();
          if (d.chk_mdr) check("mdr_out", mdr_out, d.mdr);
          check("stall_cycles", stall_cnt, d.stalls);
        end
        stall_cnt = 0;
      end
      pending = (dmem_read || dmem_write) && !dmem_resp;
    end
  end

  // One access: w wait cycles, then a response cycle.
  task automatic access(input int w, input logic [15:0] r);
    repeat (w) begin @(posedge clk); #1; end
    dmem_rdata = r;
    dmem_resp  = 1'b1;
    @(posedge clk); #1;
    dmem_resp  = 1'b0;
  endtask

  logic [15:0] pc_ctr = 16'h3000;

  task automatic run_op(input lc3b_control_word c, input logic [15:0] a, input logic [15:0] s,
                        input int w0, input logic [15:0] r0, input int w1, input logic [15:0] r1);
    valid_in = 1'b1; control_in = c; aluval_in = a; sr2_in = s;
    pc_in = pc_ctr; instruction_in = 16'h6000 | pc_ctr[7:0];
    pc_ctr = pc_ctr + 16'd2;
    access(w0, r0);
    if (c.mem_indirect) access(w1, r1);
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; control_in = '0; aluval_in = '0; sr2_in = '0;
    pc_in = '0; instruction_in = '0; dmem_rdata = '0; dmem_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a memory op and a response presented: outputs must stay quiet.
    reset = 1'b1;
    idle_inputs();
    valid_in = 1'b1; control_in = mk(1, 0, 0, 0); aluval_in = 16'h1111; dmem_resp = 1'b1;
    @(negedge clk);
    check("rst_read",  dmem_read,  1'b0);
    check("rst_write", dmem_write, 1'b0);
    check("rst_stall", stall_out,  1'b0);
    check("rst_done",  mem_done,   1'b0);
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // LDR, two wait cycles
    exp_req(1, 0, 16'h3002, 2'b11, 16'h0); exp_done(1, 16'hBEEF, 2);
    run_op(mk(1, 0, 0, 0), 16'h3002, 16'h0000, 2, 16'hBEEF, 0, 16'h0);
    // STB, odd address
    exp_req(0, 1, 16'h4000, 2'b10, 16'hA5A5); exp_done(0, 16'h0, 1);
    run_op(mk(0, 1, 1, 0), 16'h4001, 16'h12A5, 1, 16'h0000, 0, 16'h0);
    // LDB, even address
    exp_req(1, 0, 16'h4000, 2'b01, 16'h0); exp_done(1, 16'hFF90, 0);
    run_op(mk(1, 0, 1, 0), 16'h4000, 16'h0000, 0, 16'h1290, 0, 16'h0);
    // LDB, odd address, positive byte
    exp_req(1, 0, 16'h4002, 2'b10, 16'h0); exp_done(1, 16'h007F, 0);
    run_op(mk(1, 0, 1, 0), 16'h4003, 16'h0000, 0, 16'h7F12, 0, 16'h0);
    // STR at a misaligned address: bit 0 dropped, full word written
    exp_req(0, 1, 16'h2004, 2'b11, 16'hABCD); exp_done(0, 16'h0, 0);
    run_op(mk(0, 1, 0, 0), 16'h2005, 16'hABCD, 0, 16'h0000, 0, 16'h0);
    // LDI
    exp_req(1, 0, 16'h5000, 2'b11, 16'h0);
    exp_req(1, 0, 16'h6000, 2'b11, 16'h0); exp_done(1, 16'h0042, 2);
    run_op(mk(1, 0, 0, 1), 16'h5000, 16'h0000, 1, 16'h6000, 0, 16'h0042);
    // STI with mem_byte set: still word accesses, odd pointer aligned
    exp_req(1, 0, 16'h7000, 2'b11, 16'h0);
    exp_req(0, 1, 16'h8000, 2'b11, 16'h1357); exp_done(0, 16'h0, 3);
    run_op(mk(0, 1, 1, 1), 16'h7000, 16'h1357, 0, 16'h8001, 2, 16'h0000);

    // Bubble carrying memory control bits: no request
    idle_inputs();
    control_in = mk(1, 0, 0, 0); aluval_in = 16'h0F0F;
    @(negedge clk);
    check("bubble_read",  dmem_read, 1'b0);
    check("bubble_stall", stall_out, 1'b0);
    @(posedge clk); #1;

    // Reset during the final access of an LDI
    valid_in = 1'b1; control_in = mk(1, 0, 0, 1); aluval_in = 16'h5000;
    exp_req(1, 0, 16'h5000, 2'b11, 16'h0);
    exp_req(1, 0, 16'h6000, 2'b11, 16'h0);
    access(0, 16'h6000);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_read",  dmem_read, 1'b0);
    check("rst_mid_stall", stall_out, 1'b0);
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fresh LDR after reset must use its own address, not the discarded pointer
    exp_req(1, 0, 16'h1234, 2'b11, 16'h0); exp_done(1, 16'h5555, 1);
    run_op(mk(1, 0, 0, 0), 16'h1234, 16'h0000, 1, 16'h5555, 0, 16'h0);

    // ALU op with a spurious response, then a store in the very next cycle
    valid_in = 1'b1; control_in = '0; control_in.load_regfile = 1'b1;
    aluval_in = 16'h0777; sr2_in = 16'h0; pc_in = 16'h3100; instruction_in = 16'h1234;
    dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
    @(negedge clk);
    check("alu_stall",   stall_out, 1'b0);
    check("alu_rw",      {dmem_read, dmem_write}, 2'b00);
    check("alu_done",    mem_done, 1'b0);
    check("alu_aluval",  aluval_out, 16'h0777);
    check("alu_pc",      pc_out, 16'h3100);
    check("alu_instr",   instruction_out, 16'h1234);
    check("alu_control", control_out, 6'b100000);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    exp_req(0, 1, 16'h0100, 2'b11, 16'h00FF); exp_done(0, 16'h0, 0);
    valid_in = 1'b1; control_in = mk(0, 1, 0, 0); aluval_in = 16'h0100; sr2_in = 16'h00FF;
    dmem_resp = 1'b1;
    @(negedge clk);
    check("b2b_write", dmem_write, 1'b1);
    check("b2b_stall", stall_out, 1'b0);
    @(posedge clk); #1;
    idle_inputs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("req_q_empty",  req_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
